// File: rtl/binarize_stage.sv
// binarize_stage: thresholds a 10-bit grayscale stream to 3FF/000 words, forces a white border, flags framing errors.
// Ports:
//   clk, rstn           clock, synchronous active-low reset
//   input_data/in_valid pixel in, qualified by in_valid
//   in_sof              start of frame (with in_valid)
//   threshold/invert    per-frame settings, captured on accepted sof beats
//   output_data         binarized pixel (3FF or 000), valid with out_valid
//   out_sof/frame_done  first / last pixel markers aligned to out_valid
//   err_framing         sticky framing error
module binarize_stage #(
  parameter int IMG_WIDTH      = 640,
  parameter int IMG_HEIGHT     = 480,
  parameter int BORDER         = 1,
  parameter int DEFAULT_THRESH = 512
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [9:0] input_data,
  input  logic       in_valid,
  input  logic       in_sof,
  input  logic [9:0] threshold,
  input  logic       invert,
  output logic [9:0] output_data,
  output logic       out_valid,
  output logic       out_sof,
  output logic       frame_done,
  output logic       err_framing
);
  localparam int CW = IMG_WIDTH > 1 ? $clog2(IMG_WIDTH) : 1;
  localparam int RW = IMG_HEIGHT > 1 ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(IMG_HEIGHT - 1);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] col, col_nx, cur_col;
  logic [RW-1:0] row, row_nx, cur_row;
  logic [9:0] thr_q, thr_use, s1_data, s1_thr;
  logic inv_q, inv_use, s1_inv, s1_border, s1_sof, s1_last, s1_valid;
  logic accept, sof_acc, last, border, err_nx;
  // row/col hold the position of the next expected pixel; a sof beat always lands at (0,0)
  always_comb begin
    sof_acc  = in_valid && in_sof;
    accept   = in_valid && (in_sof || state == ACTIVE);
    cur_col  = in_sof ? '0 : col;
    cur_row  = in_sof ? '0 : row;
    last     = cur_col == COL_MAX && cur_row == ROW_MAX;
    state_nx = state;
    col_nx   = col;
    row_nx   = row;
    if (accept) begin
      state_nx = last ? IDLE : ACTIVE;
      col_nx   = cur_col == COL_MAX ? '0 : cur_col + 1'b1;
      row_nx   = last ? '0 : (cur_col == COL_MAX ? cur_row + 1'b1 : cur_row);
    end
    // any sof while ACTIVE is premature; any sof-less beat while IDLE is dropped
    err_nx   = in_valid && (in_sof ? state == ACTIVE : state == IDLE);
    border   = int'(cur_row) < BORDER || int'(cur_row) >= IMG_HEIGHT - BORDER ||
               int'(cur_col) < BORDER || int'(cur_col) >= IMG_WIDTH - BORDER;
    // the sof pixel itself is compared against the freshly captured settings
    thr_use  = sof_acc ? threshold : thr_q;
    inv_use  = sof_acc ? invert : inv_q;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      thr_q       <= 10'(DEFAULT_THRESH);
      inv_q       <= 1'b0;
      err_framing <= 1'b0;
    end else begin
      state       <= state_nx;
      col         <= col_nx;
      row         <= row_nx;
      thr_q       <= thr_use;
      inv_q       <= inv_use;
      err_framing <= err_framing | err_nx;
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid  <= 1'b0;
      s1_data   <= '0;
      s1_thr    <= '0;
      s1_inv    <= 1'b0;
      s1_border <= 1'b0;
      s1_sof    <= 1'b0;
      s1_last   <= 1'b0;
    end else begin
      s1_valid  <= accept;
      s1_data   <= accept ? input_data : s1_data;
      s1_thr    <= accept ? thr_use : s1_thr;
      s1_inv    <= accept ? inv_use : s1_inv;
      s1_border <= accept ? border : s1_border;
      s1_sof    <= accept && in_sof;
      s1_last   <= accept && last;
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      output_data <= 10'h3FF;
      out_valid   <= 1'b0;
      out_sof     <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      output_data <= !s1_valid ? output_data :
                     (s1_border || ((s1_data >= s1_thr) ^ s1_inv)) ? 10'h3FF : 10'h000;
      out_valid   <= s1_valid;
      out_sof     <= s1_valid && s1_sof;
      frame_done  <= s1_valid && s1_last;
    end
  end
endmodule

// File: tb/tb_binarize_stage.sv
// tb_binarize_stage: randomized self-checking bench for binarize_stage against a frame-index reference model.
module tb_binarize_stage;
  localparam int W = 4, H = 3, B = 1, N = W * H;
  logic clk = 0, rstn = 0, in_valid = 0, in_sof = 0, invert = 0;
  logic [9:0] input_data = 0, threshold = 0;
  logic [9:0] output_data;
  logic out_valid, out_sof, frame_done, err_framing;
  binarize_stage #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .BORDER(B), .DEFAULT_THRESH(512)) dut (
    .clk(clk), .rstn(rstn), .input_data(input_data), .in_valid(in_valid), .in_sof(in_sof),
    .threshold(threshold), .invert(invert), .output_data(output_data), .out_valid(out_valid),
    .out_sof(out_sof), .frame_done(frame_done), .err_framing(err_framing));
  always #5 clk = ~clk;
  typedef struct {int due; logic [9:0] d; bit s; bit f;} exp_t;
  exp_t q[$];
  int edges = 0, nchk = 0, nerr = 0, nvalid = 0;
  bit mon_en = 0, m_act = 0, m_inv = 0, m_err = 0;
  int m_k = 0;
  logic [9:0] m_thr = 512, thr_in = 512;
  bit inv_in = 0;
  logic [9:0] px[N];
  always @(posedge clk) edges <= edges + 1;
  task automatic chk(input string tag, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", tag, act, exp, edges);
    end
  endtask
  always @(negedge clk) if (mon_en) begin
    if (q.size() > 0 && q[0].due == edges) begin
      chk("out_valid", int'(out_valid), 1);
      chk("output_data", int'(output_data), int'(q[0].d));
      chk("out_sof", int'(out_sof), int'(q[0].s));
      chk("frame_done", int'(frame_done), int'(q[0].f));
      nvalid++;
      void'(q.pop_front());
    end else begin
      chk("out_valid_idle", int'(out_valid), 0);
      chk("markers_idle", int'({out_sof, frame_done}), 0);
    end
  end
  // drives one cycle, advances the model to predict that edge, then checks err_framing after it
  task automatic beat(input bit rst, input bit v, input bit s, input logic [9:0] d);
    int r, c;
    bit bord;
    rstn = !rst;
    in_valid = v && !rst;
    in_sof = s;
    input_data = d;
    if (v && s) begin threshold = thr_in; invert = inv_in; end
    else begin threshold = 10'($urandom); invert = 1'($urandom); end
    if (rst) begin
      while (q.size() > 0 && q[$].due > edges) void'(q.pop_back());
      m_act = 0; m_k = 0; m_thr = 512; m_inv = 0; m_err = 0;
    end else if (v) begin
      if (s) begin
        if (m_act) m_err = 1;
        m_act = 1; m_k = 0; m_thr = thr_in; m_inv = inv_in;
      end else if (!m_act) m_err = 1;
      if (m_act) begin
        r = m_k / W; c = m_k % W;
        bord = r < B || r >= H - B || c < B || c >= W - B;
        q.push_back('{edges + 2, (bord || ((d >= m_thr) != m_inv)) ? 10'h3FF : 10'h000, s, m_k == N - 1});
        m_k++;
        if (m_k == N) m_act = 0;
      end
    end
    @(posedge clk); #1;
    chk("err_framing", int'(err_framing), int'(m_err));
  endtask
  task automatic send_frame(input bit bub);
    for (int k = 0; k < N; k++) begin
      beat(0, 1, k == 0, px[k]);
      if (bub) beat(0, 0, 0, 10'($urandom));
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(0, 0, 0, 10'($urandom));
  endtask
  task automatic fill(input int v);
    for (int k = 0; k < N; k++) px[k] = v < 0 ? 10'($urandom) : 10'(v);
  endtask
  initial begin
    beat(1, 0, 0, 0);
    beat(1, 0, 0, 0);
    mon_en = 1;
    chk("rst_data", int'(output_data), 'h3FF);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_sof", int'(out_sof), 0);
    chk("rst_done", int'(frame_done), 0);
    chk("rst_err", int'(err_framing), 0);
    thr_in = 512; inv_in = 0;
    fill(600); send_frame(0); idle(3);
    fill(100); send_frame(0); idle(2);
    inv_in = 1; send_frame(0); idle(2);
    inv_in = 0; fill(0); px[5] = 511; px[6] = 512; send_frame(0); idle(2);
    fill(-1); nvalid = 0; send_frame(1); idle(3);
    chk("bubble_count", nvalid, N);
    fill(-1); send_frame(0); send_frame(0); idle(3);
    beat(0, 1, 0, 10'd700); beat(0, 1, 0, 10'd5); idle(3);
    chk("idle_drop_err", int'(err_framing), 1);
    beat(1, 0, 0, 0); idle(1);
    fill(-1);
    for (int k = 0; k < 5; k++) beat(0, 1, k == 0, px[k]);
    send_frame(0); idle(3);
    chk("premature_err", int'(err_framing), 1);
    for (int k = 0; k < N - 1; k++) beat(0, 1, k == 0, px[k]);
    send_frame(0); idle(5);
    chk("sticky_err", int'(err_framing), 1);
    beat(1, 0, 0, 0); idle(1);
    fill(-1);
    for (int k = 0; k < 7; k++) beat(0, 1, k == 0, px[k]);
    beat(1, 0, 0, 0); idle(4);
    thr_in = 512; inv_in = 0; fill(600); nvalid = 0; send_frame(0); idle(3);
    chk("post_reset_count", nvalid, N);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 14) == 0) begin thr_in = 10'($urandom); inv_in = 1'($urandom); end
      beat($urandom_range(0, 150) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 13) == 0, 10'($urandom));
    end
    idle(4);
    chk("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/binarize_stage.md
# binarize_stage

Pixel pre-processing stage that sits directly upstream of the 3x3 morphology filters. It converts a 10-bit grayscale stream into a binary stream of 10'h3FF/10'h000 words using a per-frame threshold. It also tracks row/column position and forces a configurable border to 10'h3FF so that the downstream AND-window sees neutral values at image edges. It flags frame-framing errors.

## Interface
- IMG_WIDTH, 640, active pixels per line (>= 2*BORDER+1)
- IMG_HEIGHT, 480, active lines per frame (>= 2*BORDER+1)
- BORDER, 1, width in pixels of the forced-white margin on all four edges (0 disables)
- DEFAULT_THRESH, 512, threshold used until the first frame start after reset
- clk  in  1  single clock; all logic on rising edge
- rstn  in  1  reset, synchronous, active-low
- input_data  in  10  grayscale pixel, qualified by in_valid
- in_valid  in  1  input_data carries a pixel this cycle
- in_sof  in  1  start of frame; meaningful only with in_valid=1, marks row 0 / col 0
- threshold  in  10  threshold, sampled only on an accepted sof beat
- invert  in  1  polarity select, sampled only on an accepted sof beat
- output_data  out  10  binary pixel: 10'h3FF or 10'h000
- out_valid  out  1  output_data valid
- out_sof  out  1  first output pixel of a frame
- frame_done  out  1  one-cycle pulse, coincident with the last pixel's out_valid
- err_framing  out  1  sticky error; cleared only by reset

## Operation
- FSM states: IDLE, ACTIVE.
  - IDLE: beats with in_valid=1, in_sof=0 are dropped and set err_framing. An in_valid=1, in_sof=1 beat moves the FSM to ACTIVE; that pixel is accepted as (row 0, col 0).
  - ACTIVE: every in_valid beat is accepted.
    - col increments. At col = IMG_WIDTH-1, col wraps to 0 and row increments.
    - At (IMG_HEIGHT-1, IMG_WIDTH-1), the FSM returns to IDLE after accepting that pixel.
  - in_sof=1 in ACTIVE on any pixel other than (0,0) of a new frame (a premature sof) sets err_framing. The frame restarts: that pixel becomes (0,0), and threshold/invert are re-sampled.
- Shadow registers thr_q and inv_q:
  - Load from threshold/invert on every accepted sof beat.
  - Reset values: DEFAULT_THRESH and 0.
  - The compare for the sof pixel itself uses the newly sampled values.
- Binarize: bit = (input_data >= thr_q) XOR inv_q. output_data = bit ? 10'h3FF : 10'h000. The compare is unsigned 10-bit.
- Border override: if row < BORDER, row >= IMG_HEIGHT-BORDER, col < BORDER, or col >= IMG_WIDTH-BORDER, then output_data = 10'h3FF regardless of the compare or invert.
- in_valid gaps (bubbles) are allowed anywhere. Counters and the pipeline hold; no output is produced for bubble cycles.
- Counter widths: $clog2(IMG_WIDTH) and $clog2(IMG_HEIGHT). No counter exceeds its limit-1.

## Timing
- Latency is exactly 2 cycles. An accepted pixel at cycle N appears with out_valid=1 at cycle N+2.
  - Stage 1 registers pixel, position flags, thr_q/inv_q use.
  - Stage 2 registers the compare, override and outputs.
- out_sof and frame_done are aligned to the out_valid of their pixel. Both are 0 on dropped beats.
- Throughput is one pixel per cycle. No backpressure; downstream always accepts.
- Reset values (first edge with rstn=0): output_data=10'h3FF, out_valid=0, out_sof=0, frame_done=0, err_framing=0. Also FSM=IDLE, row=col=0, thr_q=DEFAULT_THRESH, inv_q=0.
- Reset mid-frame flushes both pipeline stages. out_valid=0 from the first reset edge, and no pending pixel emerges after rstn returns high.
- Simultaneous last pixel and next sof (back-to-back frames): the next-cycle sof is accepted with no idle gap. frame_done of frame k and out_sof of frame k+1 appear on consecutive cycles.
- A sof beat arriving in the same cycle as the last pixel's state transition is handled by the ACTIVE rule: it is a premature sof, so err_framing=1 and the frame restarts.

## Test plan
All scenarios use IMG_WIDTH=4, IMG_HEIGHT=3, BORDER=1, DEFAULT_THRESH=512.

- Reset checks: after reset, all outputs are at reset values. Then a 12-pixel frame of 600 with threshold=512, invert=0, sof on the first pixel:
  - 12 outputs, all 10'h3FF, first out 2 cycles after the sof beat.
  - out_sof on output 1, frame_done on output 12, err_framing=0.
- Frame of 100 with threshold=512:
  - Only (1,1) and (1,2) are 10'h000; the 10 border pixels are 10'h3FF.
  - Repeat with invert=1: all 12 outputs are 10'h3FF.
- Threshold boundary: interior pixels 511 and 512 with threshold=512 give 10'h000 and 10'h3FF respectively.
  - Changing threshold mid-frame to 0 does not alter results until the next sof.
- Bubbles: insert in_valid=0 after every pixel.
  - Each output still comes exactly 2 cycles after its input.
  - Exactly 12 out_valid pulses per frame.
- Errors:
  - Pixels without sof in IDLE are dropped (no out_valid) and set err_framing=1.
  - A premature sof at pixel 6 sets err_framing=1 and restarts at (0,0); out_sof is asserted again.
  - err_framing stays set until rstn=0.
- Reset at pixel 7 of a frame: out_valid=0 at the next edge. No stale outputs afterwards, and the next sof frame behaves as in the first scenario.
